instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter AW, default 10, the instruction address width, which matches the program-counter width.
REQ-002 The block SHALL have parameter DW, default 9, the instruction width.
REQ-003 The block SHALL have port CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port init  in  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port load_en  in  1  program-load write strobe.
REQ-006 The block SHALL have port load_data  in  DW  instruction word to store.
REQ-007 The block SHALL have port load_done  in  1  end-of-program marker.
REQ-008 The block SHALL have port PC  in  AW  fetch address from the program counter.
REQ-009 The block SHALL have port req  in  1  fetch request; PC is sampled when req=1.
REQ-010 The block SHALL have port instruction  out  DW  fetched instruction word.
REQ-011 The block SHALL have port valid  out  1  instruction holds a completed fetch.
REQ-012 The block SHALL have port ready  out  1  block is in RUN and accepts fetches.
REQ-013 The block SHALL have port prog_len  out  AW+1  number of words loaded.
REQ-014 The block SHALL have port oob  out  1  sticky out-of-bounds fetch error.

Function
REQ-015 The block SHALL contain 2**AW words of DW-bit storage, written only in LOAD, read only in RUN.
REQ-016 The FSM SHALL have three states: LOAD, RUN and ERR. The reset state SHALL be LOAD.
REQ-017 In LOAD, each cycle with load_en=1 SHALL write load_data to address wr_ptr and increment wr_ptr. prog_len SHALL equal wr_ptr.
REQ-018 In LOAD, load_done=1 SHALL move the FSM to RUN on the next edge. If load_en is also 1 in that cycle, the word SHALL be written and counted first.
REQ-019 In LOAD, a write at address 2**AW-1 SHALL set prog_len to 2**AW and move the FSM to RUN automatically. No wrap-around write SHALL occur.
REQ-020 In LOAD, req SHALL be ignored and valid SHALL stay 0.
REQ-021 In RUN, a cycle with req=1 and PC<prog_len SHALL produce instruction=mem[PC] and valid=1 on the next edge. Latency SHALL be exactly 1 cycle.
REQ-022 In RUN, back-to-back req SHALL sustain one fetch per cycle. A cycle with req=0 SHALL give valid=0 next cycle, and instruction SHALL hold its last value.
REQ-023 In RUN, a cycle with req=1 and PC>=prog_len SHALL produce the following on the next edge: instruction=0, valid=0, oob=1, FSM to ERR. This includes the case prog_len=0.
REQ-024 In RUN and ERR, load_en and load_done SHALL be ignored; storage and prog_len SHALL be frozen.
REQ-025 In ERR, valid SHALL be 0, oob SHALL stay 1, and req SHALL be ignored. Only init leaves ERR.
REQ-026 ready SHALL be 1 exactly when the FSM is in RUN.
REQ-027 The PC comparison SHALL be unsigned, with PC zero-extended to AW+1 bits.

Reset
REQ-028 Asserting init SHALL immediately force the following, at any time including mid-load or mid-fetch: FSM=LOAD, wr_ptr=0, prog_len=0, instruction=0, valid=0, ready=0, oob=0.
REQ-029 Storage contents need not be cleared by init. Only words below prog_len SHALL ever be returned.
REQ-030 A fetch in flight when init asserts SHALL be discarded, with no valid pulse after init deasserts.

Verification
REQ-031 Scenario: load 0x0A5, 0x1FF, 0x003 then load_done; req with PC=0,1,2 on consecutive cycles -> valid=1 for 3 cycles carrying 0x0A5, 0x1FF, 0x003; prog_len=3; ready=1.
REQ-032 Scenario: load_en=1 with load_data=0x111 in the same cycle as load_done -> prog_len=1, RUN; fetch PC=0 returns 0x111.
REQ-033 Scenario: after 3 words, req with PC=3 -> next cycle oob=1, valid=0, ready=0; later req with PC=0 -> no valid; init -> oob=0, LOAD.
REQ-034 Scenario: 1024 consecutive load_en writes with no load_done -> prog_len=1024, auto RUN; fetch PC=1023 returns the last word; a further load_en does not change prog_len.
REQ-035 Scenario: init pulsed after 5 loaded words, mid-load -> prog_len=0, LOAD; reload 2 words + load_done -> prog_len=2; fetch PC=2 -> oob=1.
REQ-036 Scenario: load_done with zero words, then req with PC=0 -> prog_len=0, oob=1 next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a program is streamed into local storage while in LOAD.
// In RUN the block serves one-cycle-latency fetches. An out-of-bounds fetch
// parks it in ERR until the next init.
module instr_fetch_unit #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 9
) (
  input  logic          CLK,
  input  logic          init,
  input  logic          load_en,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  input  logic [AW-1:0] PC,
  input  logic          req,
  output logic [DW-1:0] instruction,
  output logic          valid,
  output logic          ready,
  output logic [AW:0]   prog_len,
  output logic          oob
);

  typedef enum logic [1:0] {StLoad, StRun, StErr} state_e;

  localparam int unsigned Depth = 1 << AW;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          oob_q, oob_d;
  logic          mem_we;
  logic          last_addr;
  logic          pc_in_range;

  // Program storage; contents survive init, only words below prog_len are ever returned
  logic [DW-1:0] mem [Depth];

  // Writing the top address fills the store, so LOAD ends without wrapping
  assign last_addr   = (wr_ptr_q[AW-1:0] == {AW{1'b1}});
  // Unsigned compare with PC zero-extended to the length width
  assign pc_in_range = ({1'b0, PC} < wr_ptr_q);

  // Next-state logic for the load/run/error sequencing and fetch datapath
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    oob_d    = oob_q;
    mem_we   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (load_en) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + (AW+1)'(1);
          if (last_addr) begin
            state_d = StRun;
          end
        end
        if (load_done) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (req) begin
          if (pc_in_range) begin
            instr_d = mem[PC];
            valid_d = 1'b1;
          end else begin
            instr_d = '0;
            oob_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StErr: begin
        // Sticky: only init leaves this state
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by init
  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      state_q  <= StLoad;
      wr_ptr_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      oob_q    <= oob_d;
    end
  end

  // Storage write port, active only in LOAD
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= load_data;
    end
  end

  assign instruction = instr_q;
  assign valid       = valid_q;
  assign ready       = (state_q == StRun);
  assign prog_len    = wr_ptr_q;
  assign oob         = oob_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// load/fetch traffic compared against a behavioural model of the program store.
module tb_instr_fetch_unit;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 9;
  localparam int          DEPTH = 1 << AW;
  localparam int          MLoad = 0;
  localparam int          MRun  = 1;
  localparam int          MErr  = 2;

  logic          CLK = 1'b0;
  logic          init;
  logic          load_en;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic [AW-1:0] PC;
  logic          req;
  logic [DW-1:0] instruction;
  logic          valid;
  logic          ready;
  logic [AW:0]   prog_len;
  logic          oob;

  instr_fetch_unit #(.AW(AW), .DW(DW)) dut (
    .CLK        (CLK),
    .init       (init),
    .load_en    (load_en),
    .load_data  (load_data),
    .load_done  (load_done),
    .PC         (PC),
    .req        (req),
    .instruction(instruction),
    .valid      (valid),
    .ready      (ready),
    .prog_len   (prog_len),
    .oob        (oob)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a program array plus its length and the last fetch result
  int            m_mode;
  int            m_len;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_instr;
  logic          m_valid;
  logic          m_oob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".instruction"}, 32'(instruction), 32'(m_instr));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".ready"}, 32'(ready), 32'(m_mode == MRun));
    chk({tag, ".prog_len"}, 32'(prog_len), 32'(m_len));
    chk({tag, ".oob"}, 32'(oob), 32'(m_oob));
  endtask

  task automatic model_reset();
    m_mode  = MLoad;
    m_len   = 0;
    m_instr = '0;
    m_valid = 1'b0;
    m_oob   = 1'b0;
  endtask

  task automatic model_edge(input logic le, input logic [DW-1:0] d, input logic done,
                            input logic [AW-1:0] pc, input logic rq);
    case (m_mode)
      MLoad: begin
        m_valid = 1'b0;
        if (le) begin
          m_mem[m_len] = d;
          m_len++;
        end
        if (done || m_len == DEPTH) m_mode = MRun;
      end
      MRun: begin
        m_valid = 1'b0;
        if (rq) begin
          if (int'(pc) < m_len) begin
            m_instr = m_mem[int'(pc)];
            m_valid = 1'b1;
          end else begin
            m_instr = '0;
            m_oob   = 1'b1;
            m_mode  = MErr;
          end
        end
      end
      default: m_valid = 1'b0;
    endcase
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic step(input string tag, input logic le, input logic [DW-1:0] d,
                      input logic done, input logic [AW-1:0] pc, input logic rq);
    load_en   = le;
    load_data = d;
    load_done = done;
    PC        = pc;
    req       = rq;
    @(posedge CLK);
    model_edge(le, d, done, pc, rq);
    #1;
    check_all(tag);
  endtask

  task automatic load_word(input logic [DW-1:0] d);
    step("load", 1'b1, d, 1'b0, '0, 1'b0);
  endtask

  task automatic finish_load();
    step("done", 1'b0, '0, 1'b1, '0, 1'b0);
  endtask

  task automatic fetch(input logic [AW-1:0] pc);
    step("fetch", 1'b0, '0, 1'b0, pc, 1'b1);
  endtask

  task automatic idle();
    step("idle", 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous init pulse mid-cycle; outputs must clear before any clock edge
  task automatic do_init();
    #2;
    init = 1'b1;
    #1;
    model_reset();
    check_all("init_async");
    @(posedge CLK);
    #1;
    init      = 1'b0;
    load_en   = 1'b0;
    load_done = 1'b0;
    req       = 1'b0;
    PC        = '0;
    load_data = '0;
    check_all("init_held");
  endtask

  initial begin
    logic [DW-1:0] last_word;
    init      = 1'b1;
    load_en   = 1'b0;
    load_data = '0;
    load_done = 1'b0;
    PC        = '0;
    req       = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge CLK);
    #1;
    init = 1'b0;

    // Three-word program, back-to-back fetches
    load_word(9'h0A5);
    load_word(9'h1FF);
    load_word(9'h003);
    step("req_in_load", 1'b0, '0, 1'b0, '0, 1'b1);
    chk("load.valid_low", 32'(valid), 32'd0);
    finish_load();
    chk("s1.prog_len", 32'(prog_len), 32'd3);
    chk("s1.ready", 32'(ready), 32'd1);
    fetch(10'd0);
    chk("s1.w0", 32'(instruction), 32'h0A5);
    chk("s1.v0", 32'(valid), 32'd1);
    fetch(10'd1);
    chk("s1.w1", 32'(instruction), 32'h1FF);
    fetch(10'd2);
    chk("s1.w2", 32'(instruction), 32'h003);
    chk("s1.v2", 32'(valid), 32'd1);
    idle();
    chk("s1.hold", 32'(instruction), 32'h003);
    chk("s1.vlow", 32'(valid), 32'd0);

    // Out-of-bounds fetch is sticky
    fetch(10'd3);
    chk("s3.oob", 32'(oob), 32'd1);
    chk("s3.valid", 32'(valid), 32'd0);
    chk("s3.ready", 32'(ready), 32'd0);
    chk("s3.instr", 32'(instruction), 32'd0);
    fetch(10'd0);
    chk("s3.err_valid", 32'(valid), 32'd0);
    step("err_load", 1'b1, 9'h055, 1'b1, '0, 1'b0);
    chk("s3.err_len", 32'(prog_len), 32'd3);
    do_init();
    chk("s3.oob_clr", 32'(oob), 32'd0);
    chk("s3.ready_clr", 32'(ready), 32'd0);

    // Write and load_done in the same cycle
    step("wr_done", 1'b1, 9'h111, 1'b1, '0, 1'b0);
    chk("s2.prog_len", 32'(prog_len), 32'd1);
    chk("s2.ready", 32'(ready), 32'd1);
    fetch(10'd0);
    chk("s2.w0", 32'(instruction), 32'h111);

    // Valid clears immediately on init; a request pending at init is discarded
    req = 1'b1;
    PC  = '0;
    do_init();
    idle();
    chk("inflight.valid", 32'(valid), 32'd0);

    // Mid-load init then reload
    for (int i = 0; i < 5; i++) load_word(DW'($urandom));
    do_init();
    chk("s5.len0", 32'(prog_len), 32'd0);
    load_word(9'h07E);
    load_word(9'h181);
    finish_load();
    chk("s5.len2", 32'(prog_len), 32'd2);
    fetch(10'd1);
    chk("s5.w1", 32'(instruction), 32'h181);
    fetch(10'd2);
    chk("s5.oob", 32'(oob), 32'd1);

    // Empty program: any fetch is out of bounds
    do_init();
    finish_load();
    fetch(10'd0);
    chk("s6.len", 32'(prog_len), 32'd0);
    chk("s6.oob", 32'(oob), 32'd1);

    // Fill the whole store; auto transition to RUN
    do_init();
    last_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last_word = DW'($urandom);
      load_word(last_word);
    end
    chk("s4.len", 32'(prog_len), 32'd1024);
    chk("s4.ready", 32'(ready), 32'd1);
    load_word(9'h0F0);
    chk("s4.len_frozen", 32'(prog_len), 32'd1024);
    fetch(10'd1023);
    chk("s4.last", 32'(instruction), 32'(last_word));
    fetch(10'd0);

    // Randomized programs and fetch traffic
    for (int r = 0; r < 6; r++) begin
      int n;
      int loaded;
      do_init();
      n = int'($urandom_range(0, 40));
      loaded = 0;
      while (loaded < n) begin
        logic le;
        logic dn;
        le = ($urandom_range(0, 3) != 0);
        if (le) loaded++;
        dn = le && (loaded == n) && ($urandom_range(0, 1) == 1);
        step("rnd_load", le, DW'($urandom), dn, AW'($urandom), 1'($urandom));
      end
      if (m_mode == MLoad) finish_load();
      for (int k = 0; k < 60; k++) begin
        logic [AW-1:0] pc;
        if (m_len > 0 && $urandom_range(0, 15) != 0) pc = AW'($urandom_range(0, m_len - 1));
        else pc = AW'($urandom);
        step("rnd_run", 1'($urandom), DW'($urandom), 1'($urandom), pc,
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
